// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//
// Up/down modulo-2^WIDTH counter that keeps a binary count register and a
// separately registered reflected-binary Gray code of the same count. Both
// registers are loaded from the same next-count value, so they always agree
// after each edge. A one-cycle wrap pulse flags the modulo rollover.
//
// Parameters
//   WIDTH     counter / code width in bits (legal range 2..16)
//
// Ports
//   clk       single clock, rising-edge active
//   rst_n     asynchronous active-low reset (clears count, code and wrap)
//   en        count enable, one step per cycle while high
//   up        direction when en=1: 1 = increment, 0 = decrement
//   load      synchronous load strobe, takes priority over en
//   load_bin  binary value loaded when load=1
//   gray_out  registered Gray code of the count
//   bin_out   registered binary count
//   wrap      registered pulse, high for the cycle after a modulo wrap
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap
);

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_UP,
    OP_DOWN,
    OP_LOAD
  } op_e;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             wrap_nxt;
  op_e              op;

  // Priority: load over count enable over hold.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = up ? OP_UP : OP_DOWN;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    unique case (op)
      OP_LOAD: bin_nxt = load_bin;
      OP_UP: begin
        bin_nxt  = bin_q + ONE;
        wrap_nxt = (bin_q == ALL_ONES);
      end
      OP_DOWN: begin
        bin_nxt  = bin_q - ONE;
        wrap_nxt = (bin_q == ZERO);
      end
      default: bin_nxt = bin_q;
    endcase
  end

  // The Gray register is fed from the next binary count rather than decoded
  // from bin_q, so gray_out is a true flop output with no input-to-output path.
  assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_counter
//
// Self-checking bench for gray_counter (WIDTH=4). Directed steps cover reset,
// a full up-count, down wrap, load priority, hold and reset mid-count, then
// randomized en/up/load traffic is compared every cycle against an integer
// model of the count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gray_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] gray_out;
  logic [W-1:0] bin_out;
  logic         wrap;

  int n_checks;
  int n_fail;
  int cnt;   // model count as a plain integer 0..MOD-1

  gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, expected finish before 1ms");
    $fatal(1, "time limit expired");
  end

  function automatic logic [W-1:0] gray_of(input int n);
    logic [W-1:0] b;
    b = W'(n);
    return b ^ (b >> 1);
  endfunction

  // Gray decode: binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [W-1:0] decode(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_vec({tag, ".bin"}, bin_out, '0);
    check_vec({tag, ".gray"}, gray_out, '0);
    check_bit({tag, ".wrap"}, wrap, 1'b0);
  endtask

  // Drive one cycle of inputs, advance the model, then check all outputs
  // just after the edge.
  task automatic cycle(input logic e, input logic u, input logic l,
                       input logic [W-1:0] lb, input string tag);
    int           nxt;
    logic         w;
    logic [W-1:0] g_prev;
    en = e; up = u; load = l; load_bin = lb;
    g_prev = gray_out;
    w = 1'b0;
    if (l) begin
      nxt = int'(lb);
    end else if (e) begin
      nxt = u ? cnt + 1 : cnt - 1;
      w   = (nxt < 0) || (nxt >= MOD);
      nxt = (nxt + MOD) % MOD;
    end else begin
      nxt = cnt;
    end
    @(posedge clk);
    #1;
    cnt = nxt;
    check_vec({tag, ".bin"}, bin_out, W'(cnt));
    check_vec({tag, ".gray"}, gray_out, gray_of(cnt));
    check_bit({tag, ".wrap"}, wrap, w);
    check_vec({tag, ".decode"}, decode(gray_out), W'(cnt));
    if (!l && e) begin
      n_checks++;
      assert ($countones(gray_out ^ g_prev) == 1) else begin
        n_fail++;
        $error("FAIL %s.onebit: observed %0d bits changed expected 1",
               tag, $countones(gray_out ^ g_prev));
      end
    end
  endtask

  localparam logic [W-1:0] UP_GRAY [16] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
    4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000
  };

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cnt      = 0;
    rst_n    = 1'b0;
    en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;

    // Outputs are zero during reset before any clock edge.
    #3;
    check_zero("reset_initial");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, '0, "hold_after_reset");

    // Asynchronous reset pulse between edges.
    cycle(1'b0, 1'b0, 1'b1, 4'b1010, "load_1010");
    #2 rst_n = 1'b0;
    #1 check_zero("async_pulse");
    #1 rst_n = 1'b1;
    cnt = 0;

    // Full up-count from 0 against the expected Gray sequence.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0, "up_count");
      check_vec("up_table", gray_out, UP_GRAY[i]);
      check_bit("up_table_wrap", wrap, i == 15);
    end

    // Down wrap from zero then one more step.
    cycle(1'b1, 1'b0, 1'b0, '0, "down_wrap");
    check_vec("down_wrap_gray", gray_out, 4'b1000);
    check_bit("down_wrap_pulse", wrap, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, "down_after_wrap");
    check_vec("down_after_gray", gray_out, 4'b1001);

    // Load wins over enable.
    cycle(1'b1, 1'b1, 1'b1, 4'b0111, "load_priority");
    check_vec("load_priority_gray", gray_out, 4'b0100);

    // Hold keeps value, no wrap.
    cycle(1'b0, 1'b1, 1'b0, '0, "hold");

    // Load at a value that would wrap on an up step: no wrap on the load,
    // then a wrap on the following up step; direction reversal right after.
    cycle(1'b0, 1'b0, 1'b1, 4'b1111, "load_1111");
    cycle(1'b1, 1'b1, 1'b1, 4'b1111, "load_over_wrap");
    cycle(1'b1, 1'b1, 1'b0, '0, "up_wrap");
    cycle(1'b1, 1'b0, 1'b0, '0, "reverse_down_wrap");
    cycle(1'b1, 1'b1, 1'b0, '0, "reverse_up_wrap");

    // Reset mid-count at 1011 with en=1, held across an edge.
    cycle(1'b0, 1'b0, 1'b1, 4'b1011, "load_1011");
    en = 1'b1; up = 1'b1; load = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    @(posedge clk);
    #1 check_zero("mid_reset_held");
    #2 rst_n = 1'b1;
    cnt = 0;
    cycle(1'b1, 1'b1, 1'b0, '0, "after_reset");
    check_vec("after_reset_gray", gray_out, 4'b0001);

    // Random traffic.
    for (int i = 0; i < 1200; i++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, W'($urandom), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter and code width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port en, input, 1 bit, a count enable that requests one step per cycle while high.
REQ-005 SHALL have port up, input, 1 bit, the count direction: 1 counts up, 0 counts down; sampled only when en=1.
REQ-006 SHALL have port load, input, 1 bit, a synchronous load strobe.
REQ-007 SHALL have port load_bin, input, WIDTH bits, the binary value to load.
REQ-008 SHALL have port gray_out, output, WIDTH bits, the registered reflected-binary Gray code of the count.
REQ-009 SHALL have port bin_out, output, WIDTH bits, the registered binary count.
REQ-010 SHALL have port wrap, output, 1 bit, a one-cycle pulse flagging a modulo wrap.

Function
REQ-011 SHALL hold an internal binary count register; bin_out is driven directly from that register.
REQ-012 SHALL hold a separate Gray register driving gray_out (registered, not decoded combinationally from bin_out); the invariant gray_out == bin_out ^ (bin_out >> 1) SHALL hold after every clock edge.
REQ-013 SHALL give priority load > en > hold on each rising edge.
REQ-014 SHALL, when load=1, set the binary count to load_bin and gray_out to load_bin ^ (load_bin >> 1), and drive wrap=0 regardless of en and up.
REQ-015 SHALL, when load=0, en=1 and up=1, set the binary count to (count + 1) mod 2^WIDTH.
REQ-016 SHALL, when load=0, en=1 and up=0, set the binary count to (count - 1) mod 2^WIDTH.
REQ-017 SHALL, when load=0 and en=0, hold all registers and drive wrap=0.
REQ-018 SHALL assert wrap for exactly the cycle after an up step from all-ones to zero, or after a down step from zero to all-ones; wrap SHALL be 0 otherwise.
REQ-019 SHALL have a latency of one clock from the sampled en/load to updated outputs, and SHALL register wrap in the same edge as the count update.
REQ-020 SHALL change exactly one bit of gray_out per enabled step, including across the wrap boundary; a load may change any number of bits.
REQ-021 SHALL support back-to-back steps every cycle with no idle cycles required, and direction reversal between consecutive cycles.
REQ-022 SHALL contain no combinational path from any input to any output.

Reset
REQ-023 SHALL, while rst_n=0, force the binary count=0, gray_out=0 and wrap=0 immediately, without waiting for a clock edge.
REQ-024 SHALL, when reset is applied mid-count (including during a load or a wrap cycle), discard the operation in progress; the first edge after rst_n rises evaluates inputs normally from count 0.

Verification
REQ-025 SHALL cover reset: with WIDTH=4, pulse rst_n low between clock edges -> gray_out=0000, bin_out=0000 and wrap=0 before the next edge.
REQ-026 SHALL cover a full up-count: 16 cycles of en=1, up=1 from 0 -> gray_out follows 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000, and wrap=1 only with the final 0000.
REQ-027 SHALL cover a down-count wrap: from 0, one cycle of en=1, up=0 -> bin_out=1111, gray_out=1000, wrap=1; the next step -> bin_out=1110, gray_out=1001, wrap=0.
REQ-028 SHALL cover load priority: load=1, load_bin=0111 with en=1, up=1 -> bin_out=0111, gray_out=0100, wrap=0.
REQ-029 SHALL cover random stimulus: at least 1000 cycles of random en/up/load with a scoreboard checking REQ-012, REQ-018 and REQ-020 every cycle, plus exhaustive Gray decode of gray_out back to bin_out.
REQ-030 SHALL cover reset mid-count: assert rst_n low at bin_out=1011 while en=1 -> all outputs 0 at once; release with en=1, up=1 -> bin_out=0001, gray_out=0001 after the first edge.
